// File: rtl/ula_ctrl.sv
// ula_ctrl: multi-cycle MIPS decoder/sequencer driving the ula ALU; J/JAL/JR decode only with ULA_CTRL_JUMP_EN.
// Retires 2..4+w cycles after accept; instr_ready only in IDLE; MEM stalls on mem_ready, abandoned after MEM_TIMEOUT.
module ula_ctrl #(
    parameter logic [3:0] MEM_TIMEOUT = 4'd15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [4:0]  alu_op,
    input  logic        alu_zero,
    output logic        src_imm,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    input  logic        mem_ready,
    output logic [1:0]  pc_sel,
    output logic        done,
    output logic        illegal
);
    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
    typedef enum logic [2:0] {K_ALU, K_BR, K_J, K_JAL, K_JR, K_LW, K_SW, K_ILL} kind_t;
    typedef struct packed {
        logic [4:0] op;
        logic       src_imm;
        logic       reg_dst;
        kind_t      kind;
    } dec_t;

    localparam dec_t DEC_RST = '{op: 5'b01111, src_imm: 1'b0, reg_dst: 1'b0, kind: K_ILL};

    state_t     state, state_nxt;
    dec_t       dec_c, dec_r;
    logic [3:0] wait_cnt;
    logic [5:0] opcode, funct;
    logic       mem_timeout;
    logic       unused_bits;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    // Only opcode and funct steer control; the register/immediate fields belong to the datapath.
    assign unused_bits = ^instr[25:6];

    always_comb begin
        dec_c = DEC_RST;
        if (opcode == 6'h00) begin
            dec_c.kind = K_ALU;
            case (funct)
                6'h24: dec_c.op = 5'b00000;
                6'h25: dec_c.op = 5'b00001;
                6'h20: dec_c.op = 5'b00010;
                6'h26: dec_c.op = 5'b00011;
                6'h27: dec_c.op = 5'b00100;
                6'h2A: dec_c.op = 5'b00101;
                6'h22: dec_c.op = 5'b00110;
                6'h2B: dec_c.op = 5'b00111;
                6'h00: begin dec_c.op = 5'b01000; dec_c.src_imm = 1'b1; end
                6'h02: begin dec_c.op = 5'b01001; dec_c.src_imm = 1'b1; end
                6'h03: begin dec_c.op = 5'b01010; dec_c.src_imm = 1'b1; end
                6'h04: dec_c.op = 5'b01011;
                6'h06: dec_c.op = 5'b01100;
                6'h07: dec_c.op = 5'b01101;
`ifdef ULA_CTRL_JUMP_EN
                6'h08: begin dec_c.op = 5'b01110; dec_c.kind = K_JR; end
`endif
                default: dec_c.kind = K_ILL;
            endcase
            dec_c.reg_dst = (dec_c.kind != K_ILL);
        end else begin
            dec_c.src_imm = 1'b1;
            dec_c.kind    = K_ALU;
            case (opcode)
                6'h08: dec_c.op = 5'b10000;
                6'h0C: dec_c.op = 5'b10001;
                6'h0D: dec_c.op = 5'b10010;
                6'h0E: dec_c.op = 5'b10011;
                6'h04: begin dec_c.op = 5'b10100; dec_c.src_imm = 1'b0; dec_c.kind = K_BR; end
                6'h05: begin dec_c.op = 5'b10101; dec_c.src_imm = 1'b0; dec_c.kind = K_BR; end
                6'h0A: dec_c.op = 5'b10111;
                6'h0B: dec_c.op = 5'b11000;
                6'h0F: dec_c.op = 5'b11001;
                6'h23: begin dec_c.op = 5'b11010; dec_c.kind = K_LW; end
                6'h2B: begin dec_c.op = 5'b11011; dec_c.kind = K_SW; end
`ifdef ULA_CTRL_JUMP_EN
                6'h02: begin dec_c.op = 5'b01111; dec_c.src_imm = 1'b0; dec_c.kind = K_J; end
                6'h03: begin dec_c.op = 5'b01111; dec_c.src_imm = 1'b0; dec_c.kind = K_JAL; end
`endif
                default: begin dec_c.src_imm = 1'b0; dec_c.kind = K_ILL; end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset)                                 dec_r <= DEC_RST;
        else if (state == S_IDLE && instr_valid)   dec_r <= dec_c;
    end

    always_ff @(posedge clock) begin
        if (reset || state != S_MEM || state_nxt != S_MEM) wait_cnt <= 4'd0;
        else                                               wait_cnt <= wait_cnt + 4'd1;
    end

    assign mem_timeout = (state == S_MEM) && !mem_ready && (wait_cnt == MEM_TIMEOUT);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (instr_valid) state_nxt = S_DECODE;
            S_DECODE: state_nxt = (dec_r.kind == K_ILL) ? S_IDLE : S_EXEC;
            S_EXEC: begin
                case (dec_r.kind)
                    K_LW, K_SW:     state_nxt = S_MEM;
                    K_BR, K_J, K_JR: state_nxt = S_IDLE;
                    default:        state_nxt = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready)        state_nxt = (dec_r.kind == K_LW) ? S_WB : S_IDLE;
                else if (mem_timeout) state_nxt = S_IDLE;
            end
            S_WB:     state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        pc_sel    = 2'd0;
        done      = 1'b0;
        illegal   = 1'b0;
        case (state)
            S_DECODE: illegal = (dec_r.kind == K_ILL);
            S_EXEC: begin
                case (dec_r.kind)
                    K_BR: begin done = 1'b1; pc_sel = alu_zero ? 2'd0 : 2'd1; end
`ifdef ULA_CTRL_JUMP_EN
                    K_J:  begin done = 1'b1; pc_sel = 2'd2; end
                    K_JR: begin done = 1'b1; pc_sel = 2'd3; end
`endif
                    default: ;
                endcase
            end
            S_MEM: begin
                mem_read  = (dec_r.kind == K_LW) && !mem_timeout;
                mem_write = (dec_r.kind == K_SW) && !mem_timeout;
                done      = (dec_r.kind == K_SW) && mem_ready;
                illegal   = mem_timeout;
            end
            S_WB: begin
                reg_write = 1'b1;
                done      = 1'b1;
`ifdef ULA_CTRL_JUMP_EN
                if (dec_r.kind == K_JAL) pc_sel = 2'd2;
`endif
            end
            default: ;
        endcase
    end

    assign instr_ready = (state == S_IDLE);
    assign alu_op      = dec_r.op;
    assign src_imm     = dec_r.src_imm;
    assign reg_dst     = dec_r.reg_dst;
endmodule
